// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: opcode constants, ALU-op encodings and register-usage decode.
package rv32i_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        ULA_ADD   = 2'b00,
        ULA_SUB   = 2'b01,
        ULA_FUNCT = 2'b10,
        ULA_PASS  = 2'b11
    } ula_op_e;

    // The rs1 field of U/J formats is immediate bits, so it must not create a dependency.
    function automatic logic opcode_uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic opcode_uses_rs2(input logic [6:0] op);
        return (op == OP_R || op == OP_S || op == OP_B);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the instruction in ID and a load in EX.
module load_use_detect
    import rv32i_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            ex_valid,
    input  logic            ex_mem_rd,
    input  logic            ex_reg_wr,
    input  logic [RA_W-1:0] ex_rd,
    output logic            load_use
);

    logic uses_rs1;
    logic uses_rs2;
    logic producer;

    always_comb begin
        uses_rs1 = opcode_uses_rs1(id_opcode);
        uses_rs2 = opcode_uses_rs2(id_opcode);
        // Stores also assert mem_rd, so reg_wr is what marks a real load producer.
        producer = ex_valid & ex_mem_rd & ex_reg_wr & (ex_rd != '0);
        load_use = id_valid & producer
                 & ((uses_rs1 & (ex_rd == id_rs1)) | (uses_rs2 & (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and external stall.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add the bubble_cnt output.
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5
`ifdef ID_EX_BUBBLE_CNT_EN
   ,parameter int unsigned CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ext_stall,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic            id_mem_rd,
    input  logic            id_mem_wr,
    input  logic            id_reg_wr,
    input  logic            id_mux_reg_wr,
    input  logic            id_mux_ula,
    input  logic [1:0]      id_ula_op,
    input  logic            id_branch,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    output logic            ex_valid,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            ex_reg_wr,
    output logic            ex_mux_reg_wr,
    output logic            ex_mux_ula,
    output logic [1:0]      ex_ula_op,
    output logic            ex_branch,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7_5,
    output logic            id_hold
`ifdef ID_EX_BUBBLE_CNT_EN
   ,output logic [CNT_W-1:0] bubble_cnt
`endif
);

    typedef struct packed {
        logic            valid;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_wr;
        logic            mux_reg_wr;
        logic            mux_ula;
        logic [1:0]      ula_op;
        logic            branch;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [2:0]      funct3;
        logic            funct7_5;
    } stage_t;

    stage_t ex_q;
    stage_t id_in;
    logic   load_use;

    load_use_detect #(.RA_W(RA_W)) u_load_use_detect (
        .id_valid  (id_valid),
        .id_opcode (id_opcode),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .ex_valid  (ex_q.valid),
        .ex_mem_rd (ex_q.mem_rd),
        .ex_reg_wr (ex_q.reg_wr),
        .ex_rd     (ex_q.rd),
        .load_use  (load_use)
    );

    assign id_hold = ext_stall | (load_use & ~flush);

    // Controls are gated by id_valid so an empty slot can never write state downstream.
    always_comb begin
        id_in            = '0;
        id_in.valid      = id_valid;
        id_in.mem_rd     = id_valid & id_mem_rd;
        id_in.mem_wr     = id_valid & id_mem_wr;
        id_in.reg_wr     = id_valid & id_reg_wr;
        id_in.mux_reg_wr = id_valid & id_mux_reg_wr;
        id_in.mux_ula    = id_valid & id_mux_ula;
        id_in.ula_op     = id_valid ? id_ula_op : 2'b00;
        id_in.branch     = id_valid & id_branch;
        id_in.pc         = id_pc;
        id_in.rs1_data   = id_rs1_data;
        id_in.rs2_data   = id_rs2_data;
        id_in.imm        = id_imm;
        id_in.rs1        = id_rs1;
        id_in.rs2        = id_rs2;
        id_in.rd         = id_rd;
        id_in.funct3     = id_funct3;
        id_in.funct7_5   = id_funct7_5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (!ext_stall) begin
            if (flush || load_use) begin
                ex_q <= '0;
            end else begin
                ex_q <= id_in;
            end
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!ext_stall && (flush || load_use)) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

    assign ex_valid      = ex_q.valid;
    assign ex_mem_rd     = ex_q.mem_rd;
    assign ex_mem_wr     = ex_q.mem_wr;
    assign ex_reg_wr     = ex_q.reg_wr;
    assign ex_mux_reg_wr = ex_q.mux_reg_wr;
    assign ex_mux_ula    = ex_q.mux_ula;
    assign ex_ula_op     = ex_q.ula_op;
    assign ex_branch     = ex_q.branch;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7_5   = ex_q.funct7_5;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction sequence, queued expectations, separate monitor.
module tb_id_ex_stage;
    import rv32i_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        mux_reg_wr;
        logic        mux_ula;
        logic [1:0]  ula_op;
        logic        branch;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7_5;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        mux_reg_wr;
        logic        mux_ula;
        logic [1:0]  ula_op;
        logic        branch;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7_5;
    } ex_t;

    typedef struct packed {
        ex_t         ex;
        logic        hold;
        logic [31:0] cnt;
    } rec_t;

    localparam int K_CAP  = 0;
    localparam int K_ZERO = 1;
    localparam int K_PREV = 2;
    localparam int K_INV  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, ext_stall;
    stim_t       s;
    logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_mux_ula, ex_branch;
    logic [1:0]  ex_ula_op;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_5;
    logic        id_hold;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .ext_stall     (ext_stall),
        .id_valid      (s.valid),
        .id_opcode     (s.opcode),
        .id_mem_rd     (s.mem_rd),
        .id_mem_wr     (s.mem_wr),
        .id_reg_wr     (s.reg_wr),
        .id_mux_reg_wr (s.mux_reg_wr),
        .id_mux_ula    (s.mux_ula),
        .id_ula_op     (s.ula_op),
        .id_branch     (s.branch),
        .id_pc         (s.pc),
        .id_rs1_data   (s.rs1_data),
        .id_rs2_data   (s.rs2_data),
        .id_imm        (s.imm),
        .id_rs1        (s.rs1),
        .id_rs2        (s.rs2),
        .id_rd         (s.rd),
        .id_funct3     (s.funct3),
        .id_funct7_5   (s.funct7_5),
        .ex_valid      (ex_valid),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .ex_reg_wr     (ex_reg_wr),
        .ex_mux_reg_wr (ex_mux_reg_wr),
        .ex_mux_ula    (ex_mux_ula),
        .ex_ula_op     (ex_ula_op),
        .ex_branch     (ex_branch),
        .ex_pc         (ex_pc),
        .ex_rs1_data   (ex_rs1_data),
        .ex_rs2_data   (ex_rs2_data),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_funct3     (ex_funct3),
        .ex_funct7_5   (ex_funct7_5),
        .id_hold       (id_hold)
`ifdef ID_EX_BUBBLE_CNT_EN
       ,.bubble_cnt    (bubble_cnt)
`endif
    );

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;
    ex_t  last_exp = '0;

    function automatic stim_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] pc, input logic [31:0] imm);
        stim_t r = '0;
        r.valid = 1'b1; r.opcode = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.pc = pc; r.imm = imm;
        r.rs1_data = 32'h1000_0000 | {27'd0, rs1};
        r.rs2_data = 32'h2000_0000 | {27'd0, rs2};
        case (op)
            OP_R:    begin r.reg_wr = 1'b1; r.ula_op = ULA_FUNCT; r.funct7_5 = pc[2]; end
            OP_I:    begin r.reg_wr = 1'b1; r.mux_ula = 1'b1; r.ula_op = ULA_FUNCT; end
            OP_LOAD: begin r.mem_rd = 1'b1; r.reg_wr = 1'b1; r.mux_reg_wr = 1'b1; r.mux_ula = 1'b1;
                           r.ula_op = ULA_ADD; r.funct3 = 3'd2; end
            OP_S:    begin r.mem_rd = 1'b1; r.mem_wr = 1'b1; r.mux_ula = 1'b1; r.funct3 = 3'd2; end
            OP_LUI:  begin r.reg_wr = 1'b1; r.mux_ula = 1'b1; r.ula_op = ULA_PASS; end
            default: r.branch = 1'b1;
        endcase
        return r;
    endfunction

    function automatic ex_t to_ex(input stim_t v, input logic keep_ctrl);
        ex_t e;
        e.valid = v.valid & keep_ctrl;       e.mem_rd = v.mem_rd & keep_ctrl;
        e.mem_wr = v.mem_wr & keep_ctrl;     e.reg_wr = v.reg_wr & keep_ctrl;
        e.mux_reg_wr = v.mux_reg_wr & keep_ctrl; e.mux_ula = v.mux_ula & keep_ctrl;
        e.ula_op = keep_ctrl ? v.ula_op : 2'b00; e.branch = v.branch & keep_ctrl;
        e.pc = v.pc; e.rs1_data = v.rs1_data; e.rs2_data = v.rs2_data; e.imm = v.imm;
        e.rs1 = v.rs1; e.rs2 = v.rs2; e.rd = v.rd; e.funct3 = v.funct3; e.funct7_5 = v.funct7_5;
        return e;
    endfunction

    task automatic step(input stim_t v, input logic r, input logic f, input logic st,
                        input logic hold_e, input int kind, input logic [31:0] cnt_e);
        rec_t rec;
        @(posedge clk);
        #1;
        s = v; rst = r; flush = f; ext_stall = st;
        case (kind)
            K_CAP:   rec.ex = to_ex(v, 1'b1);
            K_ZERO:  rec.ex = '0;
            K_PREV:  rec.ex = last_exp;
            default: rec.ex = to_ex(v, 1'b0);
        endcase
        rec.hold = hold_e;
        rec.cnt  = cnt_e;
        last_exp = rec.ex;
        q.push_back(rec);
    endtask

    // Monitor: hold is checked mid-cycle, registered outputs just after the following edge.
    initial begin
        rec_t r;
        ex_t  act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                #1;
                checks++;
                if (id_hold !== r.hold) begin
                    errors++;
                    $display("FAIL id_hold: got %b expected %b at %0t", id_hold, r.hold, $time);
                end
                @(posedge clk);
                #1;
                act = '{ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_mux_ula, ex_ula_op,
                        ex_branch, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                        ex_funct3, ex_funct7_5};
                checks++;
                if (act !== r.ex) begin
                    errors++;
                    $display("FAIL ex_bundle: got %h expected %h at %0t", act, r.ex, $time);
                end
`ifdef ID_EX_BUBBLE_CNT_EN
                checks++;
                if (bubble_cnt !== r.cnt) begin
                    errors++;
                    $display("FAIL bubble_cnt: got %0d expected %0d at %0t", bubble_cnt, r.cnt, $time);
                end
`endif
            end
        end
    end

    initial begin
        stim_t idle, add_a, lw5, add_dep, sw5, add_x5, lw0, add_x0, lw3, lui3, lw7, add_x7, lw11;
        stim_t add_x11, addi_f, inval, lw14, add_x14;
        int    guard;
        idle = '0;
        s = '0; rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
        add_a   = mk(OP_R,    5'd6,  5'd1,  5'd2,  32'h0000_0104, 32'h0);
        lw5     = mk(OP_LOAD, 5'd5,  5'd1,  5'd0,  32'h0000_0108, 32'h10);
        add_dep = mk(OP_R,    5'd6,  5'd5,  5'd7,  32'h0000_010c, 32'h0);
        sw5     = mk(OP_S,    5'd5,  5'd2,  5'd3,  32'h0000_0110, 32'h5);
        add_x5  = mk(OP_R,    5'd8,  5'd5,  5'd5,  32'h0000_0114, 32'h0);
        lw0     = mk(OP_LOAD, 5'd0,  5'd1,  5'd0,  32'h0000_0118, 32'h20);
        add_x0  = mk(OP_R,    5'd9,  5'd0,  5'd0,  32'h0000_011c, 32'h0);
        lw3     = mk(OP_LOAD, 5'd3,  5'd2,  5'd0,  32'h0000_0120, 32'h24);
        lui3    = mk(OP_LUI,  5'd4,  5'd3,  5'd3,  32'h0000_0124, 32'h1234_5000);
        lw7     = mk(OP_LOAD, 5'd7,  5'd2,  5'd0,  32'h0000_0128, 32'h28);
        add_x7  = mk(OP_R,    5'd10, 5'd7,  5'd1,  32'h0000_012c, 32'h0);
        lw11    = mk(OP_LOAD, 5'd11, 5'd2,  5'd0,  32'h0000_0130, 32'h2c);
        add_x11 = mk(OP_R,    5'd12, 5'd11, 5'd2,  32'h0000_0134, 32'h0);
        addi_f  = mk(OP_I,    5'd13, 5'd12, 5'd0,  32'h0000_0138, 32'h7);
        inval   = mk(OP_R,    5'd14, 5'd3,  5'd4,  32'h0000_013c, 32'h9);
        inval.valid = 1'b0;
        lw14    = mk(OP_LOAD, 5'd14, 5'd2,  5'd0,  32'h0000_0140, 32'h30);
        add_x14 = mk(OP_R,    5'd15, 5'd14, 5'd1,  32'h0000_0144, 32'h0);

        //     stimulus  rst   flush st    hold  expect  cnt
        step(idle,    1'b1, 1'b0, 1'b0, 1'b0, K_ZERO, 0);
        step(idle,    1'b1, 1'b0, 1'b0, 1'b0, K_ZERO, 0);
        step(add_a,   1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  0);
        step(lw5,     1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  0);
        step(add_dep, 1'b0, 1'b0, 1'b0, 1'b1, K_ZERO, 1);
        step(add_dep, 1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  1);
        step(sw5,     1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  1);
        step(add_x5,  1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  1);
        step(lw0,     1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  1);
        step(add_x0,  1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  1);
        step(lw3,     1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  1);
        step(lui3,    1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  1);
        step(lw7,     1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  1);
        step(add_x7,  1'b0, 1'b1, 1'b0, 1'b0, K_ZERO, 2);
        step(add_x7,  1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  2);
        step(lw11,    1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  2);
        step(add_x11, 1'b0, 1'b0, 1'b1, 1'b1, K_PREV, 2);
        step(add_x11, 1'b0, 1'b1, 1'b1, 1'b1, K_PREV, 2);
        step(add_x11, 1'b0, 1'b0, 1'b1, 1'b1, K_PREV, 2);
        step(add_x11, 1'b0, 1'b0, 1'b0, 1'b1, K_ZERO, 3);
        step(add_x11, 1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  3);
        step(addi_f,  1'b0, 1'b1, 1'b0, 1'b0, K_ZERO, 4);
        step(inval,   1'b0, 1'b0, 1'b0, 1'b0, K_INV,  4);
        step(lw14,    1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  4);
        step(add_x14, 1'b1, 1'b0, 1'b0, 1'b1, K_ZERO, 0);
        step(add_x14, 1'b0, 1'b0, 1'b0, 1'b0, K_CAP,  0);
        step(idle,    1'b0, 1'b0, 1'b0, 1'b0, K_INV,  0);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
